// File: rtl/rf_pkg.sv
// Shared register-file writeback types and constants.
package rf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        SRC_EX  = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    // A query address matches a pending write only when the write is live.
    function automatic logic addr_match(input logic vld, input reg_addr_t a, input reg_addr_t q);
        return vld && (a == q);
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request, RF write and hazard-query signals of rf_wb_arbiter.
interface rf_wb_arbiter_if
    import rf_pkg::*;
#(
    parameter int unsigned XLEN = rf_pkg::XLEN
);

    logic            ex_valid;
    reg_addr_t       ex_rd;
    logic [XLEN-1:0] ex_data;
    logic            ex_ready;

    logic            mem_valid;
    reg_addr_t       mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;

    logic            rf_we;
    reg_addr_t       rf_wR;
    logic [XLEN-1:0] rf_wD;

    reg_addr_t       chk_r1;
    reg_addr_t       chk_r2;
    logic            chk_hit1;
    logic            chk_hit2;
    logic            byp_v1;
    logic            byp_v2;
    logic [XLEN-1:0] byp_d1;
    logic [XLEN-1:0] byp_d2;

    // Requesters, RF and decode side.
    modport master (
        output ex_valid, ex_rd, ex_data, mem_valid, mem_rd, mem_data, chk_r1, chk_r2,
        input  ex_ready, mem_ready, rf_we, rf_wR, rf_wD,
        input  chk_hit1, chk_hit2, byp_v1, byp_v2, byp_d1, byp_d2
    );

    // Arbiter side.
    modport slave (
        input  ex_valid, ex_rd, ex_data, mem_valid, mem_rd, mem_data, chk_r1, chk_r2,
        output ex_ready, mem_ready, rf_we, rf_wR, rf_wD,
        output chk_hit1, chk_hit2, byp_v1, byp_v2, byp_d1, byp_d2
    );

endinterface

// File: rtl/rf_wb_arbiter_prio.sv
// wb_prio_arb: fixed MEM-priority 2-way arbiter with an EX starvation guard.
module wb_prio_arb #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_valid,
    input  logic req_ex,
    input  logic req_mem,
    output logic grant_ex,
    output logic grant_mem
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             starved;

    always_comb begin
        starved   = (cnt_q == CntMax);
        grant_ex  = req_ex && (!req_mem || starved);
        grant_mem = req_mem && !grant_ex;

        // An x0-only EX request (valid but not req_ex) leaves the count untouched.
        cnt_d = cnt_q;
        if (!ex_valid || grant_ex) begin
            cnt_d = '0;
        end else if (req_ex && !starved) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the RF write port between EX and MEM writeback; x0 filter, write stage, hazards.
// Optional build macro RF_WB_BYPASS_EN: forward the write-stage data instead of flagging a hit.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic               clk,
    input  logic               rst,
    rf_wb_arbiter_if.slave     bus
);

    logic            ex_x0, mem_x0;
    logic            req_ex, req_mem;
    logic            grant_ex, grant_mem, grant_any;
    wb_src_e         src;
    reg_addr_t       sel_rd;
    logic [XLEN-1:0] sel_data;

    logic            we_q;
    reg_addr_t       wr_q;
    logic [XLEN-1:0] wd_q;

    always_comb begin
        ex_x0   = (bus.ex_rd == REG_ZERO);
        mem_x0  = (bus.mem_rd == REG_ZERO);
        req_ex  = bus.ex_valid && !ex_x0;
        req_mem = bus.mem_valid && !mem_x0;
    end

    wb_prio_arb #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_prio (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (bus.ex_valid),
        .req_ex    (req_ex),
        .req_mem   (req_mem),
        .grant_ex  (grant_ex),
        .grant_mem (grant_mem)
    );

    always_comb begin
        grant_any = grant_ex || grant_mem;
        src       = grant_ex ? SRC_EX : SRC_MEM;
        sel_rd    = bus.mem_rd;
        sel_data  = bus.mem_data;
        case (src)
            SRC_EX: begin
                sel_rd   = bus.ex_rd;
                sel_data = bus.ex_data;
            end
            default: ;
        endcase
        // x0 writes complete immediately and are dropped.
        bus.ex_ready  = !rst && bus.ex_valid && (ex_x0 || grant_ex);
        bus.mem_ready = !rst && bus.mem_valid && (mem_x0 || grant_mem);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q <= 1'b0;
            wr_q <= REG_ZERO;
            wd_q <= '0;
        end else begin
            we_q <= grant_any;
            if (grant_any) begin
                wr_q <= sel_rd;
                wd_q <= sel_data;
            end
        end
    end

    assign bus.rf_we = we_q;
    assign bus.rf_wR = wr_q;
    assign bus.rf_wD = wd_q;

    logic out_m1, out_m2, req_m1, req_m2, nz1, nz2;

    always_comb begin
        nz1    = (bus.chk_r1 != REG_ZERO);
        nz2    = (bus.chk_r2 != REG_ZERO);
        out_m1 = addr_match(we_q, wr_q, bus.chk_r1);
        out_m2 = addr_match(we_q, wr_q, bus.chk_r2);
        req_m1 = addr_match(bus.ex_valid, bus.ex_rd, bus.chk_r1)
              || addr_match(bus.mem_valid, bus.mem_rd, bus.chk_r1);
        req_m2 = addr_match(bus.ex_valid, bus.ex_rd, bus.chk_r2)
              || addr_match(bus.mem_valid, bus.mem_rd, bus.chk_r2);
`ifdef RF_WB_BYPASS_EN
        bus.chk_hit1 = nz1 && req_m1;
        bus.chk_hit2 = nz2 && req_m2;
        bus.byp_v1   = nz1 && out_m1;
        bus.byp_v2   = nz2 && out_m2;
        bus.byp_d1   = (nz1 && out_m1) ? wd_q : '0;
        bus.byp_d2   = (nz2 && out_m2) ? wd_q : '0;
`else
        bus.chk_hit1 = nz1 && (out_m1 || req_m1);
        bus.chk_hit2 = nz2 && (out_m2 || req_m2);
        bus.byp_v1   = 1'b0;
        bus.byp_v2   = 1'b0;
        bus.byp_d1   = '0;
        bus.byp_d2   = '0;
`endif
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (either RF_WB_BYPASS_EN build).
module tb_rf_wb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.XLEN(32)) bus ();

    rf_wb_arbiter #(
        .STARVE_MAX (4),
        .CNT_W      (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs are already applied (after a negedge): check readies, clock once, check write stage.
    task automatic step(input string tag, input bit e_ex, input bit e_mem, input bit e_we,
                        input logic [4:0] e_wr, input logic [31:0] e_wd);
        #1;
        check({tag, ".ex_ready"}, 32'(bus.ex_ready), 32'(e_ex));
        check({tag, ".mem_ready"}, 32'(bus.mem_ready), 32'(e_mem));
        @(posedge clk);
        #1;
        check({tag, ".rf_we"}, 32'(bus.rf_we), 32'(e_we));
        check({tag, ".rf_wR"}, 32'(bus.rf_wR), 32'(e_wr));
        check({tag, ".rf_wD"}, bus.rf_wD, e_wd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.ex_valid  = 1'b0;
        bus.ex_rd     = 5'd0;
        bus.ex_data   = '0;
        bus.mem_valid = 1'b0;
        bus.mem_rd    = 5'd0;
        bus.mem_data  = '0;
        bus.chk_r1    = 5'd0;
        bus.chk_r2    = 5'd0;

        // Reset state, readies held low even with a request present.
        repeat (2) @(negedge clk);
        bus.ex_valid = 1'b1;
        bus.ex_rd    = 5'd5;
        #1;
        check("rst.rf_we", 32'(bus.rf_we), 32'd0);
        check("rst.rf_wR", 32'(bus.rf_wR), 32'd0);
        check("rst.rf_wD", bus.rf_wD, 32'd0);
        check("rst.ex_ready", 32'(bus.ex_ready), 32'd0);

        // EX only: accepted same cycle, written next cycle.
        @(negedge clk);
        rst         = 1'b0;
        bus.ex_data = 32'h1234;
        step("ex_only", 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234);
        @(negedge clk);
        bus.ex_valid = 1'b0;
        step("idle_hold", 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234);

        // Reset asserted while a write is in the output stage.
        @(negedge clk);
        bus.ex_valid = 1'b1;
        bus.ex_rd    = 5'd6;
        bus.ex_data  = 32'hABCD;
        step("pre_rst", 1'b1, 1'b0, 1'b1, 5'd6, 32'hABCD);
        rst = 1'b1;
        #1;
        check("midrst.rf_we", 32'(bus.rf_we), 32'd0);
        check("midrst.rf_wR", 32'(bus.rf_wR), 32'd0);
        check("midrst.ex_ready", 32'(bus.ex_ready), 32'd0);
        @(negedge clk);
        bus.ex_valid = 1'b0;
        rst          = 1'b0;
        step("post_rst", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        // Both held valid: MEM wins four times, then EX once; then MEM again.
        @(negedge clk);
        bus.ex_valid  = 1'b1;
        bus.ex_rd     = 5'd3;
        bus.ex_data   = 32'h3333;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd4;
        bus.mem_data  = 32'h4444;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) step($sformatf("starve%0d", i), 1'b1, 1'b0, 1'b1, 5'd3, 32'h3333);
            else        step($sformatf("starve%0d", i), 1'b0, 1'b1, 1'b1, 5'd4, 32'h4444);
            @(negedge clk);
        end

        // Dropping ex_valid clears the count, so EX waits a full four again.
        bus.ex_valid = 1'b0;
        step("ex_drop", 1'b0, 1'b1, 1'b1, 5'd4, 32'h4444);
        @(negedge clk);
        bus.ex_valid = 1'b1;
        for (int j = 0; j < 5; j++) begin
            if (j == 4) step($sformatf("reclr%0d", j), 1'b1, 1'b0, 1'b1, 5'd3, 32'h3333);
            else        step($sformatf("reclr%0d", j), 1'b0, 1'b1, 1'b1, 5'd4, 32'h4444);
            @(negedge clk);
        end

        // x0 EX alongside a real MEM request: both ready, single write to x7.
        bus.ex_rd     = 5'd0;
        bus.ex_data   = 32'hDEAD;
        bus.mem_rd    = 5'd7;
        bus.mem_data  = 32'h7777;
        step("x0_pair", 1'b1, 1'b1, 1'b1, 5'd7, 32'h7777);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        step("x0_alone", 1'b1, 1'b0, 1'b0, 5'd7, 32'h7777);

        // Write-stage hazard vs bypass on x9, requester hazard on x3.
        @(negedge clk);
        bus.ex_valid  = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd9;
        bus.mem_data  = 32'h9999;
        step("mem9", 1'b0, 1'b1, 1'b1, 5'd9, 32'h9999);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        bus.ex_valid  = 1'b1;
        bus.ex_rd     = 5'd3;
        bus.ex_data   = 32'h0303;
        bus.chk_r1    = 5'd9;
        bus.chk_r2    = 5'd3;
        #1;
`ifdef RF_WB_BYPASS_EN
        check("haz.hit1", 32'(bus.chk_hit1), 32'd0);
        check("haz.byp_v1", 32'(bus.byp_v1), 32'd1);
        check("haz.byp_d1", bus.byp_d1, 32'h9999);
`else
        check("haz.hit1", 32'(bus.chk_hit1), 32'd1);
        check("haz.byp_v1", 32'(bus.byp_v1), 32'd0);
        check("haz.byp_d1", bus.byp_d1, 32'd0);
`endif
        check("haz.hit2", 32'(bus.chk_hit2), 32'd1);
        check("haz.byp_v2", 32'(bus.byp_v2), 32'd0);
        step("ex3", 1'b1, 1'b0, 1'b1, 5'd3, 32'h0303);

        // x0 query never hits; unrelated register does not hit.
        @(negedge clk);
        bus.ex_rd  = 5'd0;
        bus.chk_r1 = 5'd0;
        bus.chk_r2 = 5'd12;
        #1;
        check("x0q.hit1", 32'(bus.chk_hit1), 32'd0);
        check("x0q.byp_v1", 32'(bus.byp_v1), 32'd0);
        check("x0q.hit2", 32'(bus.chk_hit2), 32'd0);
        @(negedge clk);
        bus.ex_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
